// File: rtl/nwc_pkg.sv
// Shared definitions for the NWC block family: data widths, modulus table, loader state encoding.
package nwc_pkg;

    localparam int NWC_N       = 4096;
    localparam int NWC_ADDR_W  = 11;
    localparam int NWC_COEFF_W = 30;
    localparam int NWC_WORD_W  = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } loader_state_e;

    // Moduli selectable by MOD_INDEX; every entry lies in (2^29, 2^30).
    function automatic logic [NWC_COEFF_W-1:0] nwc_modulus(input int unsigned mod_index);
        case (mod_index)
            32'd0:   return 30'd1073479681;
            32'd1:   return 30'd1072496641;
            default: return 30'd1073479681;
        endcase
    endfunction

endpackage

// File: rtl/nwc_coeff_reduce.sv
// Folds a 30-bit coefficient into [0, MODULUS) with one conditional subtract and flags nonzero
// bits above the coefficient field.
module nwc_coeff_reduce
    import nwc_pkg::*;
#(
    parameter logic [NWC_COEFF_W-1:0] MODULUS = 30'd1073479681
) (
    input  logic [NWC_WORD_W-1:0]  word,
    output logic [NWC_COEFF_W-1:0] coeff,
    output logic                   range_err
);

    logic [NWC_COEFF_W-1:0] value_s;

    assign value_s   = word[NWC_COEFF_W-1:0];
    assign coeff     = (value_s >= MODULUS) ? (value_s - MODULUS) : value_s;
    assign range_err = (word[NWC_WORD_W-1:NWC_COEFF_W] != 2'b00);

endmodule

// File: rtl/nwc_input_loader.sv
// Streams one 8192-coefficient batch into nwc_top's input BRAMs, starts nwc_top, waits for done.
// Build option NWC_LOADER_REDUCE_EN: values >= MODULUS are folded instead of flagged as errors.
module nwc_input_loader
    import nwc_pkg::*;
#(
    parameter logic [NWC_COEFF_W-1:0] MODULUS   = 30'd1073479681,
    parameter int                     FRAME_LOG = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWC_WORD_W-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [NWC_ADDR_W-1:0] buf_addr,
    output logic [NWC_WORD_W-1:0] buf_data,
    output logic [3:0]            buf0_wen_up,
    output logic [3:0]            buf0_wen_down,
    output logic [3:0]            buf1_wen_up,
    output logic [3:0]            buf1_wen_down,
    input  logic                  nwc_ready,
    input  logic                  nwc_done,
    output logic                  nwc_start,
    output logic                  busy,
    output logic                  err
);

    localparam logic [FRAME_LOG-1:0] K_LAST = FRAME_LOG'(2 * NWC_N - 1);
    localparam logic [FRAME_LOG-1:0] K_ONE  = {{(FRAME_LOG-1){1'b0}}, 1'b1};

    loader_state_e          state_r;
    loader_state_e          state_nxt_s;
    logic [FRAME_LOG-1:0]   k_r;
    logic                   done_q_r;
    logic                   err_r;
    logic [NWC_ADDR_W-1:0]  addr_r;
    logic [NWC_WORD_W-1:0]  data_r;
    logic [3:0]             wen_sel_r;
    logic                   start_s;
    logic                   accept_s;
    logic                   last_beat_s;
    logic                   frame_err_s;
    logic                   range_err_s;
    logic [NWC_COEFF_W-1:0] coeff_s;
    logic [1:0]             buf_sel_s;

    assign accept_s    = s_valid && (state_r == LOAD);
    assign last_beat_s = (k_r == K_LAST);
    assign frame_err_s = (s_last != last_beat_s);
    // {polynomial, lane} picks one of the four BRAMs; index 0 is polynomial 0 up-lane.
    assign buf_sel_s   = k_r[FRAME_LOG-1 -: 2];

`ifdef NWC_LOADER_REDUCE_EN
    nwc_coeff_reduce #(
        .MODULUS   (MODULUS)
    ) u_reduce (
        .word      (s_data),
        .coeff     (coeff_s),
        .range_err (range_err_s)
    );
`else
    assign coeff_s     = s_data[NWC_COEFF_W-1:0];
    assign range_err_s = (s_data[NWC_WORD_W-1:NWC_COEFF_W] != 2'b00) || (coeff_s >= MODULUS);
`endif

    // Next-state and start-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            LOAD: begin
                if (accept_s && last_beat_s) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            ARM: begin
                if (nwc_ready) begin
                    start_s     = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            RUN: begin
                // Only a fresh rising edge of done releases RUN; a stale level does not.
                if (nwc_done && !done_q_r) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Beat counter, registered BRAM write port, done history and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r       <= {FRAME_LOG{1'b0}};
            addr_r    <= {NWC_ADDR_W{1'b0}};
            data_r    <= {NWC_WORD_W{1'b0}};
            wen_sel_r <= 4'b0000;
            done_q_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_q_r <= nwc_done;
            if (accept_s) begin
                k_r       <= k_r + K_ONE;
                addr_r    <= k_r[NWC_ADDR_W-1:0];
                data_r    <= {{(NWC_WORD_W-NWC_COEFF_W){1'b0}}, coeff_s};
                wen_sel_r <= 4'b0001 << buf_sel_s;
                if (frame_err_s || range_err_s) begin
                    err_r <= 1'b1;
                end
            end else begin
                wen_sel_r <= 4'b0000;
            end
        end
    end

    assign s_ready       = (state_r == LOAD);
    assign busy          = (state_r == ARM) || (state_r == RUN);
    assign nwc_start     = start_s;
    assign err           = err_r;
    assign buf_addr      = addr_r;
    assign buf_data      = data_r;
    assign buf0_wen_up   = {4{wen_sel_r[0]}};
    assign buf0_wen_down = {4{wen_sel_r[1]}};
    assign buf1_wen_up   = {4{wen_sel_r[2]}};
    assign buf1_wen_down = {4{wen_sel_r[3]}};

endmodule

// File: tb/tb_nwc_input_loader.sv
// Directed-plus-random bench for nwc_input_loader against a beat-level reference model.
module tb_nwc_input_loader;

`ifdef NWC_LOADER_REDUCE_EN
    localparam bit REDUCE = 1'b1;
`else
    localparam bit REDUCE = 1'b0;
`endif
    localparam logic [31:0] MOD32 = 32'd1073479681;
    localparam int          FRAME = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [10:0] buf_addr;
    logic [31:0] buf_data;
    logic [3:0]  buf0_wen_up;
    logic [3:0]  buf0_wen_down;
    logic [3:0]  buf1_wen_up;
    logic [3:0]  buf1_wen_down;
    logic        nwc_ready;
    logic        nwc_done;
    logic        nwc_start;
    logic        busy;
    logic        err;
    logic [15:0] wen_all;

    int   total = 0;
    int   bad = 0;
    int   starts = 0;
    int   start_base = 0;
    int   k_model = 0;
    logic model_err = 1'b0;
    bit   gaps = 1'b0;

    nwc_input_loader dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .buf0_wen_up   (buf0_wen_up),
        .buf0_wen_down (buf0_wen_down),
        .buf1_wen_up   (buf1_wen_up),
        .buf1_wen_down (buf1_wen_down),
        .nwc_ready     (nwc_ready),
        .nwc_done      (nwc_done),
        .nwc_start     (nwc_start),
        .busy          (busy),
        .err           (err)
    );

    assign wen_all = {buf1_wen_down, buf1_wen_up, buf0_wen_down, buf0_wen_up};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nwc_start === 1'b1) starts <= starts + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat, optionally preceded by random idle cycles; checks the registered write.
    task automatic beat(input logic [31:0] d, input bit last);
        logic [31:0] v;
        logic [31:0] top;
        logic [15:0] ew;
        int poly, lane, addr;
        while (gaps && $urandom_range(15, 0) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
            check("idle_wen", 64'(wen_all), 64'd0);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        v   = d % 32'h4000_0000;
        top = d / 32'h4000_0000;
        if (v >= MOD32) begin
            if (REDUCE) v = v - MOD32;
            else model_err = 1'b1;
        end
        if (top != 32'd0) model_err = 1'b1;
        if (last != (k_model == FRAME - 1)) model_err = 1'b1;
        poly = k_model / 4096;
        lane = (k_model / 2048) % 2;
        addr = k_model % 2048;
        ew   = 16'hF << (4 * (2 * poly + lane));
        check($sformatf("beat%0d", k_model),
              {3'd0, wen_all, buf_addr, buf_data, err, s_ready},
              {3'd0, ew, 11'(addr), v, model_err, 1'(k_model != FRAME - 1)});
        k_model = (k_model + 1) % FRAME;
    endtask

    // mode 0: data = index; 1: random in range; 2: random with out-of-range values mixed in.
    task automatic stream(input int first, input int n, input int mode, input int bad_last_at);
        logic [31:0] d;
        int r;
        for (int i = first; i < first + n; i++) begin
            r = $urandom_range(7, 0);
            case (mode)
                0: d = 32'(i);
                1: d = $urandom % MOD32;
                default: begin
                    if (r == 0) d = MOD32 + $urandom_range(262142, 0);
                    else if (r == 1) d = MOD32 - 32'd1;
                    else d = $urandom % MOD32;
                end
            endcase
            beat(d, (i == FRAME - 1) || (i == bad_last_at));
        end
    endtask

    // Entered in the first ARM cycle; holds nwc_ready low for 'hold' cycles while s_valid is high.
    task automatic arm_phase(input int hold);
        start_base = starts;
        nwc_ready  = (hold == 0);
        s_valid    = 1'b1;
        s_data     = 32'h0000_1234;
        s_last     = 1'b0;
        #1;
        for (int c = 0; c < hold; c++) begin
            check($sformatf("arm_wait%0d", c), 64'({nwc_start, s_ready, busy, wen_all}),
                  64'({1'b0, 1'b0, 1'b1, (c == 0) ? 16'hF000 : 16'h0000}));
            @(posedge clk); #1;
        end
        nwc_ready = 1'b1;
        #1;
        check("start_pulse", 64'({nwc_start, s_ready, busy}), 64'({1'b1, 1'b0, 1'b1}));
        @(posedge clk); #1;
        check("start_cleared", 64'({nwc_start, s_ready, busy, wen_all}),
              64'({1'b0, 1'b0, 1'b1, 16'h0000}));
    endtask

    // RUN: a done level left over from the previous batch must drop and rise again to release.
    task automatic done_phase();
        s_valid = 1'b1;
        if (nwc_done) begin
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("run_level_hold", 64'({s_ready, busy, wen_all}), 64'({1'b0, 1'b1, 16'h0000}));
            end
            nwc_done = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                check("run_done_low", 64'({s_ready, busy, wen_all}), 64'({1'b0, 1'b1, 16'h0000}));
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                check("run_wait", 64'({s_ready, busy, wen_all}), 64'({1'b0, 1'b1, 16'h0000}));
            end
        end
        nwc_done = 1'b1;
        @(posedge clk); #1;
        check("run_exit", 64'({s_ready, busy, wen_all}), 64'({1'b1, 1'b0, 16'h0000}));
        s_valid = 1'b0;
        check("start_count", 64'(starts - start_base), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 32'd0;
        s_last    = 1'b0;
        nwc_ready = 1'b0;
        nwc_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({s_ready, busy, err, nwc_start, wen_all, buf_addr, buf_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 11'd0, 32'd0}));
        rst  = 1'b0;
        gaps = 1'b1;

        // Batch with data = index, ready already high.
        stream(0, FRAME, 0, -1);
        arm_phase(0);
        done_phase();

        // Range cases, then reset part way through a batch with s_valid high.
        beat(MOD32 + 32'd5, 1'b0);
        check("mod_plus5_data", 64'(buf_data), REDUCE ? 64'd5 : 64'(MOD32 + 32'd5));
        check("mod_plus5_err", 64'(err), REDUCE ? 64'd0 : 64'd1);
        beat(32'hC000_0001, 1'b0);
        check("tag_bits_data", 64'(buf_data), 64'd1);
        check("tag_bits_err", 64'(err), 64'd1);
        stream(2, 2998, 1, -1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h0000_0777;
        s_last  = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", 64'({s_ready, busy, err, wen_all, buf_addr, buf_data}),
              64'({1'b1, 1'b0, 1'b0, 16'h0000, 11'd0, 32'd0}));
        rst       = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        k_model   = 0;
        model_err = 1'b0;

        // Random batch with a stray s_last on beat 100 and a slow nwc_ready.
        stream(0, FRAME, 1, 100);
        arm_phase(50);
        done_phase();
        check("err_after_batch", 64'(err), 64'd1);

        // Clean reset, then a random batch with out-of-range values.
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        k_model   = 0;
        model_err = 1'b0;
        stream(0, FRAME, 2, -1);
        arm_phase($urandom_range(5, 1));
        done_phase();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
